// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - register-file write arbiter bus bundle
interface wb_write_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     pipe_wb_en;
    logic [ADDRESS_WIDTH-1:0] pipe_wb_dest;
    logic [DATA_WIDTH-1:0]    pipe_wb_data;
    logic                     lu_valid;
    logic                     lu_ready;
    logic [ADDRESS_WIDTH-1:0] lu_dest;
    logic [DATA_WIDTH-1:0]    lu_data;
    logic [ADDRESS_WIDTH-1:0] chk_addr;
    logic                     chk_hit;
    logic                     wb_stall;
    logic                     wb_err;
    logic                     rg_wrt_en;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
    logic [DATA_WIDTH-1:0]    rg_wrt_data;

    modport slave (
        input  pipe_wb_en, pipe_wb_dest, pipe_wb_data,
        input  lu_valid, lu_dest, lu_data, chk_addr,
        output lu_ready, chk_hit, wb_stall, wb_err,
        output rg_wrt_en, rg_wrt_dest, rg_wrt_data
    );

    modport master (
        output pipe_wb_en, pipe_wb_dest, pipe_wb_data,
        output lu_valid, lu_dest, lu_data, chk_addr,
        input  lu_ready, chk_hit, wb_stall, wb_err,
        input  rg_wrt_en, rg_wrt_dest, rg_wrt_data
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and long-latency results onto the register-file write port
module wb_write_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_FIFO, SEL_PIPE, SEL_BYPASS} sel_t;

    logic [ADDRESS_WIDTH-1:0] r_fifo_dest [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [STV_W-1:0]         r_starve;
    logic                     r_stall;
    logic                     r_err;
    logic                     r_wrt_en;
    logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
    logic [DATA_WIDTH-1:0]    r_wrt_data;

    logic                     w_empty;
    logic                     w_lu_ready;
    logic                     w_lu_real;
    logic                     w_pipe_real;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_hit;
    logic [STV_W-1:0]         w_starve_nxt;
    sel_t                     w_sel;

    assign w_empty     = (r_count == '0);
    // The ready check deliberately ignores a same-cycle pop to keep the path short.
    assign w_lu_ready  = !rst && (r_count < CNT_W'(FIFO_DEPTH));
    // A dest-0 result is still accepted so the producer is not blocked, then discarded.
    assign w_lu_real   = bus.lu_valid && w_lu_ready && (bus.lu_dest != '0);
    // Pipeline results arriving during a stall are dropped.
    assign w_pipe_real = bus.pipe_wb_en && (bus.pipe_wb_dest != '0) && !r_stall;
    assign w_pop       = (w_sel == SEL_FIFO);
    assign w_push      = w_lu_real && (w_sel != SEL_BYPASS);

    // Pick the write-slot owner; a stall gives the FIFO absolute priority.
    always_comb begin
        w_sel = SEL_NONE;
        if (r_stall && !w_empty) begin
            w_sel = SEL_FIFO;
        end else if (w_pipe_real) begin
            w_sel = SEL_PIPE;
        end else if (!w_empty) begin
            w_sel = SEL_FIFO;
        end else if (w_lu_real) begin
            w_sel = SEL_BYPASS;
        end
    end

    // Starve counter counts consecutive cycles the FIFO head was passed over.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve < STV_W'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    // Pending-write lookup over live FIFO slots and the write currently on the port.
    always_comb begin
        w_hit = r_wrt_en && (r_wrt_dest == bus.chk_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) && (r_fifo_dest[r_rd_ptr + PTR_W'(i)] == bus.chk_addr)) begin
                w_hit = 1'b1;
            end
        end
        if (bus.chk_addr == '0) begin
            w_hit = 1'b0;
        end
    end

    // Circular buffer of long-latency results; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_dest[r_wr_ptr] <= bus.lu_dest;
                r_fifo_data[r_wr_ptr] <= bus.lu_data;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Register the selected source onto the write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrt_en   <= 1'b0;
            r_wrt_dest <= '0;
            r_wrt_data <= '0;
        end else begin
            r_wrt_en <= (w_sel != SEL_NONE);
            case (w_sel)
                SEL_FIFO: begin
                    r_wrt_dest <= r_fifo_dest[r_rd_ptr];
                    r_wrt_data <= r_fifo_data[r_rd_ptr];
                end
                SEL_PIPE: begin
                    r_wrt_dest <= bus.pipe_wb_dest;
                    r_wrt_data <= bus.pipe_wb_data;
                end
                SEL_BYPASS: begin
                    r_wrt_dest <= bus.lu_dest;
                    r_wrt_data <= bus.lu_data;
                end
                default: ;
            endcase
        end
    end

    // Stall stays up until the posedge after the FIFO is seen empty; error is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            if (r_stall && w_empty) begin
                r_stall <= 1'b0;
            end else if (w_starve_nxt == STV_W'(STARVE_LIMIT)) begin
                r_stall <= 1'b1;
            end
            if (r_stall && bus.pipe_wb_en) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.lu_ready    = w_lu_ready;
    assign bus.chk_hit     = w_hit;
    assign bus.wb_stall    = r_stall;
    assign bus.wb_err      = r_err;
    assign bus.rg_wrt_en   = r_wrt_en;
    assign bus.rg_wrt_dest = r_wrt_dest;
    assign bus.rg_wrt_data = r_wrt_data;
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sits directly upstream of the register file and drives its single write port (write enable, destination, data).
- Merges two result sources: in-order pipeline writeback results, and out-of-order results from a long-latency unit (mul/div, load miss).
- Long-latency results are buffered in a small FIFO and drained into idle write slots. A starvation guard stalls the pipeline so the FIFO always drains.
- Provides a pending-write check that hazard logic uses to hold dependent instructions.

Parameters:
- DATA_WIDTH, 32, width of a register value.
- ADDRESS_WIDTH, 5, width of a register index.
- FIFO_DEPTH, 4, number of buffered long-latency results (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive blocked cycles before a pipeline stall is requested.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pipe_wb_en  in  1  pipeline writeback valid (no backpressure).
- pipe_wb_dest  in  ADDRESS_WIDTH  pipeline destination register.
- pipe_wb_data  in  DATA_WIDTH  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  arbiter can accept a long-latency result.
- lu_dest  in  ADDRESS_WIDTH  long-latency destination.
- lu_data  in  DATA_WIDTH  long-latency result.
- chk_addr  in  ADDRESS_WIDTH  register index to test for a pending write.
- chk_hit  out  1  chk_addr has a pending or in-flight write.
- wb_stall  out  1  request that the pipeline stop issuing writebacks.
- wb_err  out  1  sticky flag: pipe_wb_en was asserted while wb_stall was 1.
- rg_wrt_en  out  1  register file write enable.
- rg_wrt_dest  out  ADDRESS_WIDTH  register file write address.
- rg_wrt_data  out  DATA_WIDTH  register file write data.

Behaviour:
- Reset, while rst=1 at posedge:
  - FIFO emptied; starve counter cleared.
  - rg_wrt_en, rg_wrt_dest, rg_wrt_data, wb_stall and wb_err all set to 0.
  - lu_ready held 0 combinationally while rst=1.
  - Reset mid-operation discards buffered results without writing them.
- Outputs rg_wrt_* are registered: the source selected at posedge N is presented during cycle N+1. The register file samples them on the following negedge.
- Slot selection at each posedge, first match wins:
  1. wb_stall=1 and FIFO non-empty: pop the FIFO head to the output.
  2. pipe_wb_en=1 and pipe_wb_dest!=0: pipeline result to the output.
  3. FIFO non-empty: pop the FIFO head to the output.
  4. Accepted lu result with lu_dest!=0 and FIFO empty: bypass it to the output (latency 1).
  5. Otherwise rg_wrt_en=0. rg_wrt_dest and rg_wrt_data hold their previous values.
- Writes to x0 are never issued: a pipeline write with dest 0 counts as no write, and an lu result with dest 0 is accepted and discarded.
- Long-latency handshake:
  - A transfer occurs when lu_valid=1 and lu_ready=1.
  - lu_ready = !rst and (count < FIFO_DEPTH). It is not relaxed by a same-cycle pop.
  - An accepted result not bypassed is pushed at the tail.
  - Push and pop in the same cycle: count is unchanged and pointers wrap modulo FIFO_DEPTH.
- FIFO order is strict FIFO. Two buffered results to the same register are written oldest first, so the last write wins.
- Starvation guard:
  - The starve counter increments on each posedge where the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - wb_stall is registered. It is set at the posedge where the counter reaches STARVE_LIMIT and clears at the posedge after the FIFO becomes empty.
  - While wb_stall=1 the FIFO drains one entry per cycle.
  - If pipe_wb_en=1 while wb_stall=1, that pipeline result is dropped and wb_err sets; wb_err clears only on reset.
- chk_hit is combinational. It is 1 when chk_addr!=0 and chk_addr matches either any valid FIFO entry or rg_wrt_dest with rg_wrt_en=1. Otherwise it is 0.

Test Plan:
- Reset: hold rst 2 cycles with lu_valid=1, pipe_wb_en=1 -> rg_wrt_en=0, lu_ready=0, wb_stall=0 and wb_err=0 throughout; lu_ready=1 the cycle after rst drops.
- Bypass: FIFO empty, no pipe write, lu_dest=7, lu_data=0xDEADBEEF accepted at posedge N -> during N+1 rg_wrt_en=1, rg_wrt_dest=7, rg_wrt_data=0xDEADBEEF.
- Priority and ordering:
  - Stimulus: pipe writes x3=1 every cycle while lu pushes x5=0xA then x5=0xB; pipe_wb_en then drops.
  - Required: x3 writes first. The FIFO then drains x5=0xA then x5=0xB on consecutive cycles, and chk_hit(5)=1 until the 0xB write cycle ends.
- Full FIFO: push 4 results with pipe_wb_en held 1 -> lu_ready=0 after the 4th; a 5th lu_valid is not accepted until a pop frees an entry.
- Starvation:
  - Stimulus: one buffered entry with pipe_wb_en=1 continuously for 8 cycles.
  - Required: wb_stall=1 after the 8th blocked posedge. The entry is written the next cycle, and wb_stall=0 after that. Holding pipe_wb_en=1 during stall sets wb_err=1.
- x0 filtering: pipe_wb_dest=0 with FIFO entry x9=0x55 -> the x9 write is issued that slot; lu_dest=0 is accepted and never written; chk_hit(0)=0 always.
